// File: rtl/rr_mux_n_to_1.sv
// rr_mux_n_to_1
//   Round-robin N-to-1 merge of independent valid/ready channels into one
//   registered output stream. Each output word carries the index of its source
//   channel on out_sel, so a downstream 1-to-N demultiplexer can use it
//   directly as its select.
//
// Handshake: a word moves across an interface on a rising clock edge where
//   valid and ready are both 1. A producer may drop or change valid at any time
//   while ready is 0; nothing is consumed unless ready was 1 at that edge.
//
// Ports
//   clock      rising-edge clock
//   reset_     asynchronous active-low reset
//   in_valid   [N]    channel i presents a word
//   in_data    [N*W]  channel i word at bits [i*W +: W]
//   in_ready   [N]    channel i word is accepted at this edge (one-hot or 0)
//   out_valid         output register holds a word
//   out_data   [W]    held word
//   out_sel    [IDW]  index of the channel that supplied out_data
//   out_ready         consumer takes the held word at this edge
//   dbg_state         output register state (0 = EMPTY, 1 = FULL)
module rr_mux_n_to_1 #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [IDW-1:0]   out_sel,
  input  logic             out_ready,
  output logic             dbg_state
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] last_q;
  logic           free;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;
  logic           accept;

  assign out_valid = (state == S_FULL);
  assign dbg_state = state;

  // The slot can take a new word if it is empty or is being drained this edge.
  assign free   = !out_valid || out_ready;
  assign accept = free && grant_found;

  // Search starts just after the last granted channel and wraps, so the most
  // recently served channel has the lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N)) begin
        cand = cand - (IDW+1)'(N);
      end
      if (!grant_found && in_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Output register state
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = S_FULL;
    end else if (out_valid && out_ready) begin
      state_nxt = S_EMPTY;
    end
  end

  // Payload and pointer only move on accept; a drain leaves data/sel intact.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      out_data <= '0;
      out_sel  <= '0;
      last_q   <= IDW'(N - 1);
    end else if (accept) begin
      out_data <= in_data[grant_idx*W +: W];
      out_sel  <= grant_idx;
      last_q   <= grant_idx;
    end
  end

endmodule

// File: tb/tb_rr_mux_n_to_1.sv
module tb_rr_mux_n_to_1;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  // ---------------- clock / reset ----------------
  logic             clock;
  logic             reset_;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [IDW-1:0]   out_sel;
  logic             out_ready;
  logic             dbg_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  rr_mux_n_to_1 #(.N(N), .W(W), .IDW(IDW)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // One-word holding slot plus a "last served" channel number.
  bit              m_valid;
  logic [W-1:0]    m_data;
  int              m_sel;
  int              m_last;
  logic [IDW+W-1:0] exp_q[$];

  function automatic int model_grant(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    logic [N-1:0] r;
    g = model_grant(in_valid, m_last);
    r = '0;
    if ((!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Applies one clock edge with the inputs currently driven and advances the
  // model; returns at edge + 1 time unit.
  task automatic cycle();
    int g;
    bit free;
    free = !m_valid || out_ready;
    g    = model_grant(in_valid, m_last);
    @(posedge clock);
    if (free && g >= 0) begin
      m_valid = 1'b1;
      m_data  = in_data[g*W +: W];
      m_sel   = g;
      m_last  = g;
      exp_q.push_back({IDW'(g), in_data[g*W +: W]});
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_last  = N - 1;
    exp_q.delete();
  endtask

  task automatic do_reset();
    in_valid  = '0;
    out_ready = 1'b0;
    reset_    = 1'b0;
    #2;
    reset_    = 1'b1;
    model_reset();
    cycle();
  endtask

  task automatic set_all_data(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) in_data[i*W +: W] = base + W'(i);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_    = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({out_valid, out_data, out_sel, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: got v=%b d=%h s=%0d r=%b required all zero",
               out_valid, out_data, out_sel, in_ready);
    end
    @(posedge clock);
    #1;
    reset_ = 1'b1;
    // load A5 from channel 0, then stall
    in_valid = 4'b0001;
    in_data[7:0] = 8'hA5;
    cycle();
    in_valid = '0;
    cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_preload: got v=%b d=%h s=%0d required v=1 d=a5 s=0",
               out_valid, out_data, out_sel);
    end
    // asynchronous assertion mid-cycle
    reset_ = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b d=%h s=%0d required v=0 d=00 s=0",
               out_valid, out_data, out_sel);
    end
    #1;
    reset_ = 1'b1;
    cycle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_replay: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    in_valid  = 4'b0100;
    in_data   = '0;
    in_data[23:16] = 8'h3C;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100 || in_ready !== model_ready()) begin
      n_fail++;
      $display("FAIL single_ready: got %b required 0100", in_ready);
    end
    cycle();
    in_valid = '0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL single_out: got v=%b d=%h s=%0d required v=1 d=3c s=2",
               out_valid, out_data, out_sel);
    end
    cycle();
  endtask

  task automatic test_all_valid();
    do_reset();
    set_all_data(8'h10);
    in_valid  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== IDW'(i % N) ||
          out_data !== 8'h10 + W'(i % N)) begin
        n_fail++;
        $display("FAIL all_valid[%0d]: got v=%b s=%0d d=%h required v=1 s=%0d d=%h",
                 i, out_valid, out_sel, out_data, i % N, 8'h10 + W'(i % N));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_all_data(8'h10);
    in_valid  = '1;
    out_ready = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (out_data !== 8'h11 || out_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_setup: got d=%h s=%0d required d=11 s=1", out_data, out_sel);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (in_ready !== '0) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: got %b required 0000", i, in_ready);
      end
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_sel !== 2'd1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d required v=1 d=11 s=1",
                 i, out_valid, out_data, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b required 0100", in_ready);
    end
    cycle();
    n_checks++;
    if (out_sel !== 2'd2 || out_data !== 8'h12) begin
      n_fail++;
      $display("FAIL bp_release_out: got s=%0d d=%h required s=2 d=12", out_sel, out_data);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_all_data(8'h40);
    in_valid  = 4'b1001;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_ready0: got %b required 0001", in_ready);
    end
    cycle();
    n_checks++;
    if (out_sel !== 2'd0 || out_data !== 8'h40) begin
      n_fail++;
      $display("FAIL wrap_first: got s=%0d d=%h required s=0 d=40", out_sel, out_data);
    end
    #1;
    n_checks++;
    if (in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_ready3: got %b required 1000", in_ready);
    end
    cycle();
    n_checks++;
    if (out_sel !== 2'd3 || out_data !== 8'h43) begin
      n_fail++;
      $display("FAIL wrap_second: got s=%0d d=%h required s=3 d=43", out_sel, out_data);
    end
  endtask

  task automatic test_drain();
    // continues from the FULL state left by test_wrap (channel 3, 8'h43)
    in_valid  = '0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== '0) begin
      n_fail++;
      $display("FAIL drain_ready: got %b required 0000", in_ready);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h43 || out_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL drain_out: got v=%b d=%h s=%0d required v=0 d=43 s=3",
               out_valid, out_data, out_sel);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [IDW+W-1:0] exp_word;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (in_ready !== model_ready()) begin
        n_fail++;
        $display("FAIL rand_ready[%0d]: got %b required %b", c, in_ready, model_ready());
      end
      // word leaving at this edge must be the oldest one accepted
      if (m_valid && out_ready && exp_q.size() > 0) begin
        exp_word = exp_q.pop_front();
        n_checks++;
        if ({out_sel, out_data} !== exp_word) begin
          n_fail++;
          $display("FAIL rand_order[%0d]: got s=%0d d=%h required s=%0d d=%h",
                   c, out_sel, out_data, exp_word[IDW+W-1:W], exp_word[W-1:0]);
        end
      end
      cycle();
      n_checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_sel !== IDW'(m_sel)) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d required v=%b d=%h s=%0d",
                 c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
    in_valid = '0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_wrap();
    test_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_n_to_1.md
Name: rr_mux_n_to_1

Overview:
Round-robin N-to-1 multiplexer with a registered output. It merges N independent valid/ready input channels into a single output stream. Each output word carries the source channel index on out_sel, so a downstream 1-to-N demultiplexer uses it directly as its select command. It is the sending end of the channel-select path that the demultiplexer blocks decode.

Parameters:
N, 4, number of input channels (N >= 2)
W, 8, data width per channel
IDW, 2, width of channel index; must satisfy 2^IDW >= N

Ports:
clock  input  1  rising-edge clock
reset_  input  1  asynchronous, active-low reset
in_valid  input  N  bit i: channel i presents a word
in_data  input  N*W  channel i word at bits [i*W+W-1 : i*W]
in_ready  output  N  bit i: channel i word accepted this edge
out_valid  output  1  output register holds a word
out_data  output  W  held word
out_sel  output  IDW  index of channel that supplied out_data
out_ready  input  1  consumer accepts the held word this edge

Behaviour:
- Reset (reset_ = 0, asynchronous, regardless of clock):
  - out_valid = 0, out_data = 0, out_sel = 0.
  - Round-robin pointer last = N-1, so channel 0 has first priority.
  - A word held at reset assertion is dropped; nothing is replayed.
- Output register has two states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- Slot free: free = !out_valid | out_ready (combinational).
- Grant: the first i with in_valid[i] = 1, searching (last+1) mod N, (last+2) mod N, ..., last, with wrap-around.
- in_ready:
  - in_ready[g] = free for the granted index g; all other bits are 0.
  - All bits are 0 when no in_valid is set.
  - in_ready is combinational from in_valid and out_ready; there is no combinational path from in_* to out_*.
- At each clock edge:
  - Accept (free and a grant exists): out_data <= word of channel g; out_sel <= g; out_valid <= 1; last <= g.
  - Drain only (out_valid & out_ready, no grant): out_valid <= 0; out_data and out_sel hold their values.
  - Stall (out_valid & !out_ready): out_data and out_sel must stay stable; no in_ready bit is asserted.
  - Idle: nothing changes; last is updated only on accept.
- Simultaneous drain and accept in one cycle is legal and gives 1 word/clock sustained throughput.
- Latency: exactly 1 clock from accept edge to out_valid = 1 with that word.
- Fairness: with all N inputs continuously valid and out_ready = 1, grants cycle 0,1,...,N-1,0,... Any continuously valid channel is served within N accepts.
- Ordering: words from the same channel leave in arrival order; the block holds at most one word in total.
- Input side need not hold in_valid stable; a word is only consumed on an edge where its in_ready = 1.

Test Plan:
1. Reset sequence: assert reset_ = 0 mid-stall with out_valid = 1, out_data = 8'hA5 -> out_valid = 0, out_data = 0, out_sel = 0 immediately, before the next clock edge.
2. Single channel: in_valid = 4'b0100, in_data[23:16] = 8'h3C, out_ready = 1 -> in_ready = 4'b0100; next cycle out_valid = 1, out_data = 8'h3C, out_sel = 2.
3. All channels valid (data 8'h10..8'h13), out_ready = 1 for 8 clocks -> out_sel sequence 0,1,2,3,0,1,2,3, one word per clock, data matches source.
4. Backpressure: out_ready = 0 for 5 clocks with out_data = 8'h11, out_sel = 1 held -> outputs stable, in_ready = 0; out_ready = 1 -> next grant goes to channel 2, not 1.
5. Wrap-around: last = 3, in_valid = 4'b1001 -> channel 0 granted first, then channel 3.
6. Drain with no input: FULL, out_ready = 1, in_valid = 0 -> out_valid drops to 0; out_data and out_sel retain their previous values.
